// File: rtl/ldl_sfifo_v2_if.sv
// Handshake/data bundle for ldl_sfifo_v2: producer/consumer side (master) and FIFO side (slave).
// Carries write/read requests, flush, data and all status flags.
interface ldl_sfifo_v2_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          flush;
    logic          we;
    logic [DW-1:0] din;
    logic          re;
    logic [DW-1:0] dout;
    logic          empty;
    logic          full;
    logic          afull;
    logic          aempty;
    logic [AW:0]   wcnt;
    logic          ovf;
    logic          udf;

    modport master (
        output flush, we, din, re,
        input  dout, empty, full, afull, aempty, wcnt, ovf, udf
    );

    modport slave (
        input  flush, we, din, re,
        output dout, empty, full, afull, aempty, wcnt, ovf, udf
    );
endinterface

// File: rtl/ldl_sfifo_v2.sv
// Synchronous single-clock FIFO with almost-full/almost-empty flags, flush and show-ahead option.
// Define SFIFO_V2_ERR_EN to build the sticky overflow/underflow flags; otherwise ovf/udf are tied 0.
module ldl_sfifo_v2 #(
    parameter int DW        = 8,
    parameter int AW        = 4,
    parameter int AHEAD     = 1,
    parameter int AFULL_TH  = (1 << AW) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst,
    ldl_sfifo_v2_if.slave     bus
);
    localparam int          DEPTH      = 1 << AW;
    localparam logic [AW:0] ONE        = (AW+1)'(1);
    localparam logic [AW:0] FULL_LVL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_TH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   cnt;
    logic [DW-1:0] rd_q;
    logic [DW-1:0] dout_c;
    logic          clr;
    logic          empty;
    logic          full;
    logic          re_acc;
    logic          we_acc;

    // Occupancy is the pointer distance; the extra MSB separates full from empty.
    assign cnt    = wptr - rptr;
    assign empty  = (cnt == '0);
    assign full   = (cnt == FULL_LVL);
    assign clr    = rst | bus.flush;
    assign re_acc = bus.re & ~empty & ~clr;
    assign we_acc = bus.we & (~full | re_acc) & ~clr;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (clr) begin
            wptr <= '0;
            rptr <= '0;
            rd_q <= '0;
        end else begin
            if (we_acc) wptr <= wptr + ONE;
            if (re_acc) begin
                rptr <= rptr + ONE;
                rd_q <= mem[rptr[AW-1:0]];
            end
        end
    end

    // NOTE: the storage array has no reset; its contents are unreachable until rewritten, and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (we_acc) mem[wptr[AW-1:0]] <= bus.din;
    end

    generate
        if (AHEAD != 0) begin : g_ahead
            // Head entry is presented directly; when empty the last popped word is held.
            always_comb begin
                // NOTE: default assigned first so no path leaves dout_c unassigned (no latch).
                dout_c = rd_q;
                if (!empty) dout_c = mem[rptr[AW-1:0]];
            end
        end else begin : g_reg
            assign dout_c = rd_q;
        end
    endgenerate

`ifdef SFIFO_V2_ERR_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.we && full && !bus.re) ovf_q <= 1'b1;
            if (bus.re && empty)           udf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.udf = udf_q;
`else
    assign bus.ovf = 1'b0;
    assign bus.udf = 1'b0;
`endif

    assign bus.dout   = dout_c;
    assign bus.empty  = empty;
    assign bus.full   = full;
    assign bus.afull  = (cnt >= AFULL_LVL);
    assign bus.aempty = (cnt <= AEMPTY_LVL);
    assign bus.wcnt   = cnt;
endmodule
